add_mul_sgn_seq: RTL and testbench
==================================

# add_mul_sgn_seq

Iterative signed adder-multiplier computing P = (XS+XC)*Y, with optional accumulation of the previous result. The multiplier is retired stepBits bits per cycle under a valid/ready handshake. It sits beside the combinational carry-save multipliers as the area-lean, full-precision option: the XS+XC sum cannot overflow, and the result is one bit wider than widthX+widthY.

## Interface
- widthX, 8: width of XS and XC; widthX >= 2
- widthY, 8: width of Y; widthY >= 2
- stepBits, 2: multiplier bits retired per cycle; 1 <= stepBits <= widthX+1
- speed, 1: passed to the internal Add instance (0/1/2)
- Derived: wX = widthX+1; N = ceil(wX/stepBits); widthP = widthX+widthY+1
- CLK  in  1  clock; all state updates on the rising edge
- RSTN  in  1  asynchronous active-low reset
- START_VALID  in  1  operand set valid
- START_READY  out  1  block can accept operands
- XS  in  widthX  signed multiplier operand (sum part)
- XC  in  widthX  signed multiplier operand (carry part)
- Y  in  widthY  signed multiplicand
- ACC  in  1  1 = add the new product to the currently held P; 0 = start from zero
- P  out  widthP  signed result
- P_VALID  out  1  P holds a completed result
- P_READY  in  1  consumer accepts P

## Operation
- States: IDLE, CALC, DONE. Reset values: state=IDLE, P=0, P_VALID=0, START_READY=1, step counter=0.
- START_READY = (state==IDLE). P_VALID = (state==DONE).
- Accept on START_VALID & START_READY:
  - Register X = sext(XS,wX)+sext(XC,wX), sign-extended to N*stepBits bits.
  - Register Y.
  - Load accumulator with P if ACC=1, else 0.
  - Go to CALC with counter=0.
- CALC step k (0..N-1):
  - acc += (d_k * sext(Y)) << (k*stepBits), modulo 2^widthP.
  - d_k = chunk k of X. Chunks k<N-1 are unsigned; chunk N-1 is signed (two's complement).
  - After step N-1, go to DONE.
- DONE: P = acc, held stable. On P_READY, go to IDLE. P keeps its value after the handshake so that the next ACC=1 operation can use it.
- Width rules:
  - Without ACC the product always fits in widthP bits, and P equals the exact value.
  - With ACC the result wraps modulo 2^widthP. There is no saturation and no overflow flag.
- Inputs are ignored outside IDLE. START_VALID in CALC or DONE has no effect.
- RSTN low at any time, including mid-CALC or in DONE: immediate return to reset values, and the in-flight operation is discarded.
- P_READY outside DONE is ignored.

## Timing
- Accept edge t0. CALC occupies edges t1..tN. P_VALID rises after edge tN, so it is high in cycle N+1 after acceptance.
- Earliest next accept is the cycle after the P handshake. DONE->IDLE takes one edge, so throughput is one result per N+2 cycles with P_READY held high.
- P and P_VALID come directly from registers. There is no combinational path from inputs to outputs.
- START_READY depends only on state. It does not depend combinationally on START_VALID or P_READY.

## Structure
- Package add_mul_seq_pkg:
  - state enum (IDLE, CALC, DONE);
  - function stepCount(wX, stepBits) returning N;
  - localparam helpers for widthP and the padded X width.
- Sub-module add_mul_step (combinational): given chunk, a last-chunk flag, Y and shift k, produces the widthP-bit partial product. The accumulate add reuses Add with width=widthP and speed=speed.
- The top level holds the FSM, X/Y/acc registers and the counter (ceil(log2 N) bits, at least 1).

## Test plan
- widthX=widthY=8, stepBits=2 (N=5); XS=127, XC=127, Y=-128, ACC=0 -> P=-32512 (17'h18100), P_VALID high exactly 6 cycles after accept.
- Same config; XS=-128, XC=-128, Y=-128 -> P=32768 (17'h08000). This confirms the XS+XC sum does not overflow and the last-chunk sign weighting is correct.
- Follow the previous case with ACC=1, XS=1, XC=0, Y=-1 -> P=32767. Then ACC=0, XS=0, XC=0, Y=5 -> P=0.
- Backpressure: hold P_READY=0 for 3 cycles in DONE and pulse START_VALID with new operands -> P stable, START_READY=0, operands not taken. After P_READY=1, START_READY returns one cycle later.
- Reset mid-CALC (RSTN low at step 2) -> P=0, P_VALID=0, START_READY=1 asynchronously. The next operation 3*4 (XS=2, XC=1, Y=4) gives P=12.
- stepBits sweep {1, 3, 9} with 1000 random operand/ACC sequences against the model (XS+XC)*Y+ACC*Pprev mod 2^widthP. Latency must equal N+1 every time.

Source files
------------

// File: rtl/add_mul_sgn_seq_pkg.sv
// Shared types and sizing helpers for the iterative signed adder-multiplier.
package add_mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned SPEED_RIPPLE = 0;
  localparam int unsigned SPEED_PLAIN  = 1;
  localparam int unsigned SPEED_CSEL   = 2;

  function automatic int unsigned stepCount(input int unsigned wX, input int unsigned stepBits);
    return (wX + stepBits - 1) / stepBits;
  endfunction

  function automatic int unsigned prodWidth(input int unsigned widthX, input int unsigned widthY);
    return widthX + widthY + 1;
  endfunction

  // X register holds the full XS+XC sum, padded to a whole number of chunks.
  function automatic int unsigned padWidth(input int unsigned widthX, input int unsigned stepBits);
    return stepCount(widthX + 1, stepBits) * stepBits;
  endfunction

  function automatic int unsigned counterWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_mul_sgn_seq_if.sv
// Operand/result handshake bundle for add_mul_sgn_seq.
interface add_mul_sgn_seq_if #(
  parameter int unsigned widthX = 8,
  parameter int unsigned widthY = 8
) ();
  localparam int unsigned widthP = widthX + widthY + 1;

  logic              START_VALID;
  logic              START_READY;
  logic [widthX-1:0] XS;
  logic [widthX-1:0] XC;
  logic [widthY-1:0] Y;
  logic              ACC;
  logic [widthP-1:0] P;
  logic              P_VALID;
  logic              P_READY;

  modport master (
    output START_VALID, XS, XC, Y, ACC, P_READY,
    input  START_READY, P, P_VALID
  );

  modport slave (
    input  START_VALID, XS, XC, Y, ACC, P_READY,
    output START_READY, P, P_VALID
  );
endinterface

// File: rtl/add_mul_sgn_seq_add.sv
// Parameterised adder: speed 0 ripple, 1 plain '+', 2 carry-select halves.
module Add #(
  parameter int unsigned width = 8,
  parameter int unsigned speed = 1
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] s_o
);
  if (speed == 0) begin : g_ripple
    logic c;
    always_comb begin
      s_o = '0;
      c   = 1'b0;
      for (int unsigned i = 0; i < width; i++) begin
        s_o[i] = a_i[i] ^ b_i[i] ^ c;
        c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
      end
    end
  end else if (speed == 2) begin : g_csel
    localparam int unsigned LO = width / 2;
    localparam int unsigned HI = width - LO;
    logic [LO:0]   lo;
    logic [HI-1:0] hi0;
    logic [HI-1:0] hi1;
    // Upper half is computed for both carry-ins and selected by the lower carry.
    assign lo  = {1'b0, a_i[LO-1:0]} + {1'b0, b_i[LO-1:0]};
    assign hi0 = a_i[width-1:LO] + b_i[width-1:LO];
    assign hi1 = a_i[width-1:LO] + b_i[width-1:LO] + HI'(1);
    assign s_o = {(lo[LO] ? hi1 : hi0), lo[LO-1:0]};
  end else begin : g_plain
    assign s_o = a_i + b_i;
  end
endmodule

// File: rtl/add_mul_sgn_seq_step.sv
// Partial product of one multiplier chunk: (chunk * sext(Y)) << (k*stepBits), mod 2^widthP.
module add_mul_step #(
  parameter int unsigned widthY   = 8,
  parameter int unsigned widthP   = 17,
  parameter int unsigned stepBits = 2,
  parameter int unsigned cntWidth = 3
) (
  input  logic [stepBits-1:0] chunk_i,
  input  logic                last_i,
  input  logic [widthY-1:0]   y_i,
  input  logic [cntWidth-1:0] k_i,
  output logic [widthP-1:0]   pp_o
);
  logic signed [widthP-1:0] d_ext;
  logic signed [widthP-1:0] y_ext;
  logic signed [widthP-1:0] prod;

  // Only the top chunk carries the sign of X; lower chunks are plain magnitudes.
  always_comb begin
    d_ext = widthP'(chunk_i);
    if (last_i) d_ext = widthP'($signed(chunk_i));
    y_ext = widthP'($signed(y_i));
    prod  = d_ext * y_ext;
    pp_o  = prod << (k_i * stepBits);
  end
endmodule

// File: rtl/add_mul_sgn_seq.sv
// Iterative signed P = (XS+XC)*Y (+ previous P), retiring stepBits multiplier bits per cycle.
module add_mul_sgn_seq
  import add_mul_seq_pkg::*;
#(
  parameter int unsigned widthX   = 8,
  parameter int unsigned widthY   = 8,
  parameter int unsigned stepBits = 2,
  parameter int unsigned speed    = 1
) (
  input logic              CLK,
  input logic              RSTN,
  add_mul_sgn_seq_if.slave bus
);
  localparam int unsigned wX     = widthX + 1;
  localparam int unsigned N      = stepCount(wX, stepBits);
  localparam int unsigned wXP    = padWidth(widthX, stepBits);
  localparam int unsigned widthP = prodWidth(widthX, widthY);
  localparam int unsigned CW     = counterWidth(N);

  state_t              state_q, state_d;
  logic [wXP-1:0]      x_q, x_d;
  logic [widthY-1:0]   y_q, y_d;
  logic [widthP-1:0]   acc_q, acc_d;
  logic [widthP-1:0]   p_q, p_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [wX-1:0]       x_sum;
  logic [wXP-1:0]      x_pad;
  logic [stepBits-1:0] chunk;
  logic                last;
  logic [widthP-1:0]   pp;
  logic [widthP-1:0]   acc_sum;

  // One extra bit makes the XS+XC sum exact; padding keeps the sign in the top chunk.
  assign x_sum = {bus.XS[widthX-1], bus.XS} + {bus.XC[widthX-1], bus.XC};
  assign x_pad = wXP'($signed(x_sum));
  assign chunk = x_q[cnt_q*stepBits +: stepBits];
  assign last  = (cnt_q == CW'(N - 1));

  add_mul_step #(
    .widthY  (widthY),
    .widthP  (widthP),
    .stepBits(stepBits),
    .cntWidth(CW)
  ) u_step (
    .chunk_i(chunk),
    .last_i (last),
    .y_i    (y_q),
    .k_i    (cnt_q),
    .pp_o   (pp)
  );

  Add #(
    .width(widthP),
    .speed(speed)
  ) u_add (
    .a_i(acc_q),
    .b_i(pp),
    .s_o(acc_sum)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.START_VALID) begin
          x_d     = x_pad;
          y_d     = bus.Y;
          acc_d   = bus.ACC ? p_q : '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        if (last) begin
          p_d     = acc_sum;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.P_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.START_READY = (state_q == IDLE);
  assign bus.P_VALID     = (state_q == DONE);
  assign bus.P           = p_q;

endmodule

// File: tb/tb_add_mul_sgn_seq.sv
// Bench for add_mul_sgn_seq: directed cases plus a randomised stepBits sweep against an arithmetic model.
module tb_add_mul_sgn_seq;
  localparam int L = 4;
  localparam int SB [L] = '{2, 1, 3, 9};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        sv_a  [L];
  logic        acc_a [L];
  logic        pr_a  [L];
  logic        sr_a  [L];
  logic        pv_a  [L];
  logic [7:0]  xs_a  [L];
  logic [7:0]  xc_a  [L];
  logic [7:0]  y_a   [L];
  logic [16:0] p_a   [L];
  logic [16:0] prev_a[L];

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < L; g++) begin : lane
    add_mul_sgn_seq_if #(.widthX(8), .widthY(8)) bus ();
    assign bus.START_VALID = sv_a[g];
    assign bus.XS          = xs_a[g];
    assign bus.XC          = xc_a[g];
    assign bus.Y           = y_a[g];
    assign bus.ACC         = acc_a[g];
    assign bus.P_READY     = pr_a[g];
    assign sr_a[g]         = bus.START_READY;
    assign pv_a[g]         = bus.P_VALID;
    assign p_a[g]          = bus.P;
    add_mul_sgn_seq #(
      .widthX  (8),
      .widthY  (8),
      .stepBits(SB[g]),
      .speed   (g % 3)
    ) dut (
      .CLK (clk),
      .RSTN(rstn),
      .bus (bus)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [7:0] xs, input logic [7:0] xc,
                                        input logic [7:0] y, input logic acc,
                                        input logic [16:0] prev);
    longint v;
    v = longint'($signed(xs)) + longint'($signed(xc));
    v = v * longint'($signed(y));
    if (acc) v = v + longint'(prev);
    return v[16:0];
  endfunction

  // Latency is counted in cycles after the accept edge; P_VALID is expected in cycle N+1.
  task automatic run_op(input int l, input logic [7:0] xs, input logic [7:0] xc,
                        input logic [7:0] y, input logic acc,
                        output logic [16:0] p, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    xs_a[l] = xs; xc_a[l] = xc; y_a[l] = y; acc_a[l] = acc; sv_a[l] = 1'b1;
    while (!sr_a[l] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    sv_a[l] = 1'b0;
    lat = 1;
    while (!pv_a[l] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    p = p_a[l];
    pr_a[l] = 1'b1;
    @(negedge clk);
    pr_a[l] = 1'b0;
  endtask

  initial begin
    logic [16:0] p;
    int          lat;
    logic [7:0]  rx, rc, ry;
    logic        ra;
    logic [16:0] exp;
    int          n;

    for (int i = 0; i < L; i++) begin
      sv_a[i] = 1'b0; acc_a[i] = 1'b0; pr_a[i] = 1'b0;
      xs_a[i] = '0; xc_a[i] = '0; y_a[i] = '0; prev_a[i] = '0;
    end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < L; i++) begin
      check("rst_p", 32'(p_a[i]), 32'h0);
      check("rst_pvalid", 32'(pv_a[i]), 32'h0);
      check("rst_sready", 32'(sr_a[i]), 32'h1);
    end

    run_op(0, 8'd127, 8'd127, 8'h80, 1'b0, p, lat);
    check("p_maxpos", 32'(p), 32'h18100);
    check("lat_maxpos", 32'(lat), 32'd6);
    run_op(0, 8'h80, 8'h80, 8'h80, 1'b0, p, lat);
    check("p_maxneg", 32'(p), 32'h08000);
    check("lat_maxneg", 32'(lat), 32'd6);
    run_op(0, 8'd1, 8'd0, 8'hFF, 1'b1, p, lat);
    check("p_acc", 32'(p), 32'h07FFF);
    run_op(0, 8'd0, 8'd0, 8'd5, 1'b0, p, lat);
    check("p_zero", 32'(p), 32'h0);

    // Backpressure: (3+4)*5 = 35 held while new operands are offered in DONE.
    @(negedge clk);
    xs_a[0] = 8'd3; xc_a[0] = 8'd4; y_a[0] = 8'd5; acc_a[0] = 1'b0; sv_a[0] = 1'b1;
    @(negedge clk);
    sv_a[0] = 1'b0;
    lat = 1;
    while (!pv_a[0] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd6);
    check("bp_p", 32'(p_a[0]), 32'd35);
    for (int c = 0; c < 3; c++) begin
      xs_a[0] = 8'd10; xc_a[0] = 8'd10; y_a[0] = 8'd10; sv_a[0] = 1'b1;
      @(negedge clk);
      check("bp_hold_p", 32'(p_a[0]), 32'd35);
      check("bp_hold_sready", 32'(sr_a[0]), 32'h0);
      check("bp_hold_pvalid", 32'(pv_a[0]), 32'h1);
    end
    sv_a[0] = 1'b0;
    pr_a[0] = 1'b1;
    @(negedge clk);
    pr_a[0] = 1'b0;
    check("bp_sready_back", 32'(sr_a[0]), 32'h1);
    check("bp_pvalid_low", 32'(pv_a[0]), 32'h0);
    check("bp_p_kept", 32'(p_a[0]), 32'd35);
    run_op(0, 8'd0, 8'd0, 8'd0, 1'b1, p, lat);
    check("bp_acc_reuse", 32'(p), 32'd35);

    // Asynchronous reset during CALC step 2.
    @(negedge clk);
    xs_a[0] = 8'd50; xc_a[0] = 8'd50; y_a[0] = 8'd50; acc_a[0] = 1'b0; sv_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv_a[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_p", 32'(p_a[0]), 32'h0);
    check("arst_pvalid", 32'(pv_a[0]), 32'h0);
    check("arst_sready", 32'(sr_a[0]), 32'h1);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < L; i++) prev_a[i] = '0;
    run_op(0, 8'd2, 8'd1, 8'd4, 1'b0, p, lat);
    check("arst_next", 32'(p), 32'd12);
    check("arst_next_lat", 32'(lat), 32'd6);
    prev_a[0] = 17'd12;

    for (int l = 0; l < L; l++) begin
      n = (9 + SB[l] - 1) / SB[l];
      for (int t = 0; t < 1000; t++) begin
        rx = 8'($urandom);
        rc = 8'($urandom);
        ry = 8'($urandom);
        ra = 1'($urandom_range(0, 1));
        exp = model(rx, rc, ry, ra, prev_a[l]);
        run_op(l, rx, rc, ry, ra, p, lat);
        check($sformatf("rnd_p_sb%0d", SB[l]), 32'(p), 32'(exp));
        check($sformatf("rnd_lat_sb%0d", SB[l]), 32'(lat), 32'(n + 1));
        prev_a[l] = exp;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
